// File: rtl/bridge_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bridge_pkg: I/O address map and seven-segment glyph table         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package bridge_pkg;

    localparam logic [31:0] IO_BASE    = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_DIG   = IO_BASE + 32'h0000_0000;
    localparam logic [31:0] ADDR_TIMER = IO_BASE + 32'h0000_0020;
    localparam logic [31:0] ADDR_LED   = IO_BASE + 32'h0000_0060;
    localparam logic [31:0] ADDR_SW    = IO_BASE + 32'h0000_0070;
    localparam logic [31:0] ADDR_BTN   = IO_BASE + 32'h0000_0078;

    localparam int SEG_W = 8;

    // Active-low {DP,G..A}, DP off; entry n sits at bits [8n+7:8n].
    localparam logic [16*SEG_W-1:0] GLYPH_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nib);
        return GLYPH_TABLE[int'(nib)*SEG_W +: SEG_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_bridge_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_bridge_if: CPU bus port (single-cycle, zero-latency reads)     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface io_bridge_if;

    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;

    modport master (
        output Bus_addr,
        output Bus_wen,
        output Bus_wdata,
        input  Bus_rdata
    );

    modport slave (
        input  Bus_addr,
        input  Bus_wen,
        input  Bus_wdata,
        output Bus_rdata
    );

endinterface
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_scan: multiplexed 8-digit hex display driver                 |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module seg7_scan
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  wire logic             cpu_clk,
    input  wire logic             cpu_rst,
    input  wire logic [31:0]      value,
    output logic      [7:0]       dig_en,
    output logic      [SEG_W-1:0] dig_seg
);

    localparam int              CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [3:0]       w_nib;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded straight from the value register so a DIG write shows one edge later.
    always_comb begin
        w_nib   = value[{r_idx, 2'b00} +: 4];
        dig_en  = ~(8'd1 << r_idx);
        dig_seg = hex_glyph(w_nib);
    end

endmodule
`default_nettype wire

// File: rtl/io_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_bridge: CPU bus decode to data RAM and memory-mapped I/O       |
// | Optional free-running timer enabled by BRIDGE_TIMER_EN            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module io_bridge
    import bridge_pkg::*;
#(
    parameter int DRAM_AW  = 16,
    parameter int SCAN_DIV = 50000,
    parameter int LED_W    = 24
) (
    input  wire logic               cpu_clk,
    input  wire logic               cpu_rst,
    io_bridge_if.slave              bus,
    output logic      [DRAM_AW-1:0] dram_addr,
    output logic                    dram_wen,
    output logic      [31:0]        dram_wdata,
    input  wire logic [31:0]        dram_rdata,
    input  wire logic [LED_W-1:0]   sw,
    input  wire logic [4:0]         button,
    output logic      [LED_W-1:0]   led,
    output logic      [7:0]         dig_en,
    output logic      [SEG_W-1:0]   dig_seg
);

    logic [LED_W-1:0] r_led;
    logic [31:0]      r_dig;
    logic [LED_W-1:0] r_sw_s1;
    logic [LED_W-1:0] r_sw_s2;
    logic [4:0]       r_btn_s1;
    logic [4:0]       r_btn_s2;

    logic             w_is_io;
    logic             w_sel_dig;
    logic             w_sel_led;
    logic             w_sel_sw;
    logic             w_sel_btn;
    logic [31:0]      w_rdata;
    logic             w_unused_lsb;

    // Byte offset within a word plays no part in decode.
    assign w_unused_lsb = ^bus.Bus_addr[1:0];

    assign w_is_io   = (bus.Bus_addr >= IO_BASE);
    assign w_sel_dig = (bus.Bus_addr[31:2] == ADDR_DIG[31:2]);
    assign w_sel_led = (bus.Bus_addr[31:2] == ADDR_LED[31:2]);
    assign w_sel_sw  = (bus.Bus_addr[31:2] == ADDR_SW[31:2]);
    assign w_sel_btn = (bus.Bus_addr[31:2] == ADDR_BTN[31:2]);

`ifdef BRIDGE_TIMER_EN
    logic [31:0] r_timer;
    logic        w_sel_timer;

    assign w_sel_timer = (bus.Bus_addr[31:2] == ADDR_TIMER[31:2]);

    // A CPU load takes priority over the free-running increment.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_timer <= '0;
        end else if (bus.Bus_wen && w_sel_timer) begin
            r_timer <= bus.Bus_wdata;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end
`endif

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_led    <= '0;
            r_dig    <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= button;
            r_btn_s2 <= r_btn_s1;
            if (bus.Bus_wen && w_sel_dig) begin
                r_dig <= bus.Bus_wdata;
            end
            if (bus.Bus_wen && w_sel_led) begin
                r_led <= bus.Bus_wdata[LED_W-1:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (!w_is_io) begin
            w_rdata = dram_rdata;
        end else if (w_sel_dig) begin
            w_rdata = r_dig;
        end else if (w_sel_led) begin
            w_rdata[LED_W-1:0] = r_led;
        end else if (w_sel_sw) begin
            w_rdata[LED_W-1:0] = r_sw_s2;
        end else if (w_sel_btn) begin
            w_rdata[4:0] = r_btn_s2;
        end
`ifdef BRIDGE_TIMER_EN
        else if (w_sel_timer) begin
            w_rdata = r_timer;
        end
`endif
    end

    assign bus.Bus_rdata = w_rdata;
    assign dram_addr     = bus.Bus_addr[DRAM_AW+1:2];
    assign dram_wen      = bus.Bus_wen && !w_is_io;
    assign dram_wdata    = bus.Bus_wdata;
    assign led           = r_led;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .value   (r_dig),
        .dig_en  (dig_en),
        .dig_seg (dig_seg)
    );

endmodule
`default_nettype wire

// File: tb/tb_io_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_io_bridge: directed + random bus traffic against a ref model   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_io_bridge;

    localparam int DRAM_AW  = 16;
    localparam int SCAN_DIV = 4;
    localparam int LED_W    = 24;

    logic               cpu_clk = 1'b0;
    logic               cpu_rst;
    logic [DRAM_AW-1:0] dram_addr;
    logic               dram_wen;
    logic [31:0]        dram_wdata;
    logic [31:0]        dram_rdata;
    logic [LED_W-1:0]   sw;
    logic [4:0]         button;
    logic [LED_W-1:0]   led;
    logic [7:0]         dig_en;
    logic [7:0]         dig_seg;

    io_bridge_if bus_if ();

    io_bridge #(
        .DRAM_AW  (DRAM_AW),
        .SCAN_DIV (SCAN_DIV),
        .LED_W    (LED_W)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .bus        (bus_if),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .button     (button),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: architectural registers plus pin history and edge count.
    logic [31:0]      m_dig;
    logic [LED_W-1:0] m_led;
    logic [31:0]      m_timer;
    int               m_edges;
    logic [LED_W-1:0] m_sw_hist[$];
    logic [4:0]       m_btn_hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic [31:0] dr);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        if (a < 32'hFFFF_F000) return dr;
        case (wa)
            32'hFFFF_F000: return m_dig;
            32'hFFFF_F020: begin
`ifdef BRIDGE_TIMER_EN
                return m_timer;
`else
                return 32'd0;
`endif
            end
            32'hFFFF_F060: return {8'd0, m_led};
            32'hFFFF_F070: return (m_sw_hist.size() == 2) ? {8'd0, m_sw_hist[0]} : 32'd0;
            32'hFFFF_F078: return (m_btn_hist.size() == 2) ? {27'd0, m_btn_hist[0]} : 32'd0;
            default:       return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_dig   = '0;
        m_led   = '0;
        m_timer = '0;
        m_edges = 0;
        m_sw_hist.delete();
        m_btn_hist.delete();
    endtask

    task automatic model_edge();
        logic [31:0] wa;
        wa = bus_if.Bus_addr & 32'hFFFF_FFFC;
        if (cpu_rst) begin
            model_reset();
        end else begin
            if (bus_if.Bus_wen && wa == 32'hFFFF_F000) m_dig = bus_if.Bus_wdata;
            if (bus_if.Bus_wen && wa == 32'hFFFF_F060) m_led = bus_if.Bus_wdata[LED_W-1:0];
            if (bus_if.Bus_wen && wa == 32'hFFFF_F020) m_timer = bus_if.Bus_wdata;
            else                                       m_timer = m_timer + 32'd1;
            m_sw_hist.push_back(sw);
            m_btn_hist.push_back(button);
            if (m_sw_hist.size() > 2) void'(m_sw_hist.pop_front());
            if (m_btn_hist.size() > 2) void'(m_btn_hist.pop_front());
            m_edges++;
        end
    endtask

    // One bus cycle: drive, check combinational/registered outputs mid-cycle, advance model at the edge.
    task automatic cycle(input logic [31:0] a, input logic w, input logic [31:0] d);
        int          dig;
        logic [31:0] nib;
        bus_if.Bus_addr  = a;
        bus_if.Bus_wen   = w;
        bus_if.Bus_wdata = d;
        @(negedge cpu_clk);
        dig = (m_edges / SCAN_DIV) % 8;
        nib = (m_dig >> (4 * dig)) & 32'hF;
        check("rdata",      bus_if.Bus_rdata, exp_rdata(a, dram_rdata));
        check("dram_wen",   {31'd0, dram_wen}, {31'd0, (w && a < 32'hFFFF_F000)});
        check("dram_addr",  {16'd0, dram_addr}, (a >> 2) & 32'h0000_FFFF);
        check("dram_wdata", dram_wdata, d);
        check("led",        {8'd0, led}, {8'd0, m_led});
        check("dig_en",     {24'd0, dig_en}, {24'd0, ~(8'd1 << dig)});
        check("dig_seg",    {24'd0, dig_seg}, {24'd0, glyph(nib[3:0])});
        @(posedge cpu_clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [1:0] lo;
        lo = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0:       return 32'hFFFF_F000 | {30'd0, lo};
            1:       return 32'hFFFF_F020 | {30'd0, lo};
            2:       return 32'hFFFF_F060 | {30'd0, lo};
            3:       return 32'hFFFF_F070 | {30'd0, lo};
            4:       return 32'hFFFF_F078 | {30'd0, lo};
            5:       return 32'hFFFF_F000 + $urandom_range(1, 1023) * 4 + {30'd0, lo};
            6:       return 32'hFFFF_EFFC | {30'd0, lo};
            default: return $urandom() % 32'hFFFF_F000;
        endcase
    endfunction

    initial begin
        cpu_rst          = 1'b1;
        bus_if.Bus_addr  = '0;
        bus_if.Bus_wen   = 1'b0;
        bus_if.Bus_wdata = '0;
        dram_rdata       = '0;
        sw               = '0;
        button           = '0;
        repeat (2) @(posedge cpu_clk);
        model_reset();
        #1;
        cpu_rst = 1'b0;

        // Reset state
        check("rst_led",     {8'd0, led}, 32'd0);
        check("rst_dig_en",  {24'd0, dig_en}, 32'h0000_00FE);
        check("rst_dig_seg", {24'd0, dig_seg}, 32'h0000_00C0);
        cycle(32'hFFFF_F000, 1'b0, 32'd0);

        // DRAM write then read-through
        cycle(32'h0000_0010, 1'b1, 32'h1234_5678);
        dram_rdata = 32'hCAFE_0001;
        cycle(32'h0000_0010, 1'b0, 32'd0);

        // LED write, then readback with upper bits zero
        cycle(32'hFFFF_F060, 1'b1, 32'hFFAB_CDEF);
        check("led_after_wr", {8'd0, led}, 32'h00AB_CDEF);
        cycle(32'hFFFF_F060, 1'b0, 32'd0);

        // Switch/button synchroniser latency
        sw     = 24'h00_00A5;
        button = 5'h13;
        repeat (3) cycle(32'hFFFF_F070, 1'b0, 32'd0);
        check("sw_synced", bus_if.Bus_rdata, 32'h0000_00A5);
        repeat (3) cycle(32'hFFFF_F078, 1'b0, 32'd0);

        // Display scan across a full rotation and beyond
        cycle(32'hFFFF_F000, 1'b1, 32'h8765_4321);
        repeat (40) cycle(32'hFFFF_F000, 1'b0, 32'd0);

        // Timer load and wrap
        cycle(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFE);
        repeat (3) cycle(32'hFFFF_F020, 1'b0, 32'd0);

        // Random traffic with occasional mid-run reset
        for (int i = 0; i < 3000; i++) begin
            cpu_rst    = ($urandom_range(0, 199) == 0);
            dram_rdata = $urandom();
            if ($urandom_range(0, 3) == 0) sw = LED_W'($urandom());
            if ($urandom_range(0, 3) == 0) button = 5'($urandom());
            cycle(rand_addr(), 1'($urandom_range(0, 1)), $urandom());
        end
        cpu_rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
